// File: rtl/dma_bus_if.sv
// Bus bundle for dma_bus: CPU request side, main bus, high (IO) bus, OAM write port and busy flag.
// The slave modport is the dma_bus view; the master modport is the CPU/memory environment view.
interface dma_bus_if;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_d_out;
  logic        cpu_write;
  logic [7:0]  cpu_d_in;

  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_write;
  logic [7:0]  mem_rdata;

  logic [7:0]  io_addr;
  logic [7:0]  io_wdata;
  logic        io_write;
  logic [7:0]  io_rdata;

  logic [7:0]  oam_addr;
  logic [7:0]  oam_wdata;
  logic        oam_we;

  logic        dma_busy;

  modport slave (
    input  cpu_addr, cpu_d_out, cpu_write, mem_rdata, io_rdata,
    output cpu_d_in, mem_addr, mem_wdata, mem_write,
    output io_addr, io_wdata, io_write, oam_addr, oam_wdata, oam_we, dma_busy
  );

  modport master (
    output cpu_addr, cpu_d_out, cpu_write, mem_rdata, io_rdata,
    input  cpu_d_in, mem_addr, mem_wdata, mem_write,
    input  io_addr, io_wdata, io_write, oam_addr, oam_wdata, oam_we, dma_busy
  );
endinterface

// File: rtl/dma_bus.sv
// CPU bus splitter with OAM DMA engine: FF46 write copies 160 bytes from {src_hi,00} into OAM.
// Optional macro DMA_ECHO_MAP_EN folds sources E0-FF down by 0x20 (echo-RAM mirror).
module dma_bus (
  input  logic       clk,
  input  logic       rst,
  dma_bus_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, START, ACTIVE} state_t;

  state_t     state;
  state_t     next_state;
  logic [7:0] idx;
  logic [7:0] dma_src;
  logic [7:0] src_hi;
  logic       src_write;
  logic       io_sel;
  logic       last_byte;

  assign io_sel    = (bus.cpu_addr[15:8] == 8'hFF);
  assign src_write = bus.cpu_write && (bus.cpu_addr == 16'hFF46);
  assign last_byte = (idx == 8'd159);

`ifdef DMA_ECHO_MAP_EN
  assign src_hi = (dma_src >= 8'hE0) ? (dma_src - 8'h20) : dma_src;
`else
  assign src_hi = dma_src;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Index and source register; a source write always rewinds the index for a fresh transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx     <= 8'h00;
      dma_src <= 8'h00;
    end else begin
      if (src_write) begin
        dma_src <= bus.cpu_d_out;
      end
      if (src_write || state != ACTIVE || last_byte) begin
        idx <= 8'h00;
      end else begin
        idx <= idx + 8'h01;
      end
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (src_write) next_state = START;
      START:   next_state = src_write ? START : ACTIVE;
      ACTIVE: begin
        if (src_write)      next_state = START;
        else if (last_byte) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Main bus belongs to the DMA while ACTIVE; CPU accesses below FF00 are then blocked.
  always_comb begin
    bus.mem_addr  = bus.cpu_addr;
    bus.mem_wdata = bus.cpu_d_out;
    bus.mem_write = 1'b0;
    bus.io_addr   = bus.cpu_addr[7:0];
    bus.io_wdata  = bus.cpu_d_out;
    bus.io_write  = 1'b0;
    bus.cpu_d_in  = 8'hFF;
    bus.oam_addr  = idx;
    bus.oam_wdata = bus.mem_rdata;
    bus.oam_we    = 1'b0;
    bus.dma_busy  = (state != IDLE);

    if (state == ACTIVE) begin
      bus.mem_addr = {src_hi, idx};
      bus.oam_we   = 1'b1;
    end

    if (io_sel) begin
      if (bus.cpu_addr[7:0] == 8'h46) begin
        bus.cpu_d_in = dma_src;
      end else begin
        bus.io_write = bus.cpu_write;
        bus.cpu_d_in = bus.io_rdata;
      end
    end else if (state != ACTIVE) begin
      bus.mem_write = bus.cpu_write;
      bus.cpu_d_in  = bus.mem_rdata;
    end
  end

endmodule

// File: tb/tb_dma_bus.sv
// Randomized self-checking bench for dma_bus: a transfer-timeline model is compared on every
// falling edge, plus directed scenarios with literal expectations.
module tb_dma_bus;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  bit   check_en;
  int   pulses;

  // Model: m_t = -1 idle, 0 the start cycle, 1..160 copying byte m_t-1.
  int         m_t;
  logic [7:0] m_src;

  dma_bus_if bus ();

  dma_bus dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  function automatic logic [7:0] memf(input logic [15:0] a);
    return a[15:8] ^ a[7:0] ^ 8'h3C;
  endfunction

  function automatic logic [7:0] iof(input logic [7:0] a);
    return ~a + 8'h11;
  endfunction

  assign bus.mem_rdata = memf(bus.mem_addr);
  assign bus.io_rdata  = iof(bus.io_addr);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] addr, input logic [7:0] data, input logic wr);
    @(posedge clk);
    #1;
    bus.cpu_addr  = addr;
    bus.cpu_d_out = data;
    bus.cpu_write = wr;
  endtask

  task automatic idleCycle();
    applyStimulus(16'h0100, 8'h00, 1'b0);
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_t   <= -1;
      m_src <= 8'h00;
    end else if (bus.cpu_write && bus.cpu_addr == 16'hFF46) begin
      m_src <= bus.cpu_d_out;
      m_t   <= 0;
    end else if (m_t >= 0) begin
      m_t <= (m_t == 160) ? -1 : m_t + 1;
    end
  end

  function automatic logic [7:0] model_src_hi();
`ifdef DMA_ECHO_MAP_EN
    return (m_src >= 8'hE0) ? m_src - 8'h20 : m_src;
`else
    return m_src;
`endif
  endfunction

  always @(negedge clk) begin
    if (bus.oam_we === 1'b1) pulses++;
  end

  always @(negedge clk) begin
    if (check_en) begin
      logic        active;
      logic [15:0] dma_a;
      active = (m_t >= 1 && m_t <= 160);
      dma_a  = {model_src_hi(), 8'(m_t - 1)};
      checkOutput("dma_busy", {15'd0, bus.dma_busy}, {15'd0, m_t >= 0});
      checkOutput("oam_we", {15'd0, bus.oam_we}, {15'd0, active});
      if (active) begin
        checkOutput("oam_addr", {8'd0, bus.oam_addr}, {8'd0, 8'(m_t - 1)});
        checkOutput("dma_mem_addr", bus.mem_addr, dma_a);
        checkOutput("oam_wdata", {8'd0, bus.oam_wdata}, {8'd0, memf(dma_a)});
      end
      if (bus.cpu_addr[15:8] == 8'hFF) begin
        checkOutput("io_addr", {8'd0, bus.io_addr}, {8'd0, bus.cpu_addr[7:0]});
        if (bus.cpu_addr[7:0] == 8'h46) begin
          checkOutput("io_write_ff46", {15'd0, bus.io_write}, 16'd0);
          checkOutput("rd_ff46", {8'd0, bus.cpu_d_in}, {8'd0, m_src});
        end else begin
          checkOutput("io_write", {15'd0, bus.io_write}, {15'd0, bus.cpu_write});
          checkOutput("rd_io", {8'd0, bus.cpu_d_in}, {8'd0, iof(bus.cpu_addr[7:0])});
          if (bus.cpu_write) checkOutput("io_wdata", {8'd0, bus.io_wdata}, {8'd0, bus.cpu_d_out});
        end
        checkOutput("mem_write_io", {15'd0, bus.mem_write}, 16'd0);
      end else begin
        checkOutput("io_write_mem", {15'd0, bus.io_write}, 16'd0);
        if (active) begin
          checkOutput("rd_blocked", {8'd0, bus.cpu_d_in}, 16'h00FF);
          checkOutput("mem_write_blk", {15'd0, bus.mem_write}, 16'd0);
        end else begin
          checkOutput("cpu_mem_addr", bus.mem_addr, bus.cpu_addr);
          checkOutput("mem_write", {15'd0, bus.mem_write}, {15'd0, bus.cpu_write});
          checkOutput("rd_mem", {8'd0, bus.cpu_d_in}, {8'd0, memf(bus.cpu_addr)});
          if (bus.cpu_write) checkOutput("mem_wdata", {8'd0, bus.mem_wdata}, {8'd0, bus.cpu_d_out});
        end
      end
    end
  end

  initial begin
    int p0;
    logic [15:0] a;
    checks   = 0;
    errors   = 0;
    pulses   = 0;
    check_en = 1'b0;
    rst           = 1'b1;
    bus.cpu_addr  = 16'h0100;
    bus.cpu_d_out = 8'h00;
    bus.cpu_write = 1'b0;
    #12;
    checkOutput("rst_busy", {15'd0, bus.dma_busy}, 16'd0);
    checkOutput("rst_oam_we", {15'd0, bus.oam_we}, 16'd0);
    rst = 1'b0;
    check_en = 1'b1;

    // Reset read-back and IDLE routing
    applyStimulus(16'hFF46, 8'h00, 1'b0);
    @(negedge clk);
    checkOutput("lit_ff46_reset", {8'd0, bus.cpu_d_in}, 16'h0000);
    applyStimulus(16'hC000, 8'h12, 1'b1);
    @(negedge clk);
    checkOutput("lit_idle_mem_write", {15'd0, bus.mem_write}, 16'd1);
    checkOutput("lit_idle_mem_addr", bus.mem_addr, 16'hC000);
    checkOutput("lit_idle_mem_wdata", {8'd0, bus.mem_wdata}, 16'h0012);

    // Basic transfer from C0
    p0 = pulses;
    applyStimulus(16'hFF46, 8'hC0, 1'b1);
    @(negedge clk);
    checkOutput("lit_ff46_no_io_write", {15'd0, bus.io_write}, 16'd0);
    idleCycle();
    @(negedge clk);
    checkOutput("lit_start_busy", {15'd0, bus.dma_busy}, 16'd1);
    checkOutput("lit_start_no_oam", {15'd0, bus.oam_we}, 16'd0);
    for (int i = 0; i < 160; i++) begin
      if (i == 10) applyStimulus(16'h0150, 8'h00, 1'b0);
      else if (i == 11) applyStimulus(16'hFF85, 8'h5A, 1'b1);
      else idleCycle();
      @(negedge clk);
      if (i == 0 || i == 159) begin
        checkOutput("lit_oam_addr", {8'd0, bus.oam_addr}, 16'(i));
        checkOutput("lit_dma_addr", bus.mem_addr, 16'hC000 + 16'(i));
      end
      if (i == 10) begin
        checkOutput("lit_blocked_rd", {8'd0, bus.cpu_d_in}, 16'h00FF);
        checkOutput("lit_blocked_addr", bus.mem_addr, 16'hC00A);
      end
      if (i == 11) begin
        checkOutput("lit_io_addr", {8'd0, bus.io_addr}, 16'h0085);
        checkOutput("lit_io_write", {15'd0, bus.io_write}, 16'd1);
        checkOutput("lit_io_wdata", {8'd0, bus.io_wdata}, 16'h005A);
      end
    end
    idleCycle();
    @(negedge clk);
    checkOutput("lit_done_busy", {15'd0, bus.dma_busy}, 16'd0);
    checkOutput("lit_pulses_160", 16'(pulses - p0), 16'd160);

    // Restart mid-transfer: 50 bytes, then START, then 160 bytes from D0
    p0 = pulses;
    applyStimulus(16'hFF46, 8'hC0, 1'b1);
    for (int i = 0; i < 50; i++) idleCycle();
    applyStimulus(16'hFF46, 8'hD0, 1'b1);
    idleCycle();
    @(negedge clk);
    checkOutput("lit_restart_start", {15'd0, bus.oam_we}, 16'd0);
    idleCycle();
    @(negedge clk);
    checkOutput("lit_restart_addr", bus.mem_addr, 16'hD000);
    for (int i = 0; i < 162; i++) idleCycle();
    @(negedge clk);
    checkOutput("lit_pulses_210", 16'(pulses - p0), 16'd210);

    // Echo mapping of source E1
    applyStimulus(16'hFF46, 8'hE1, 1'b1);
    idleCycle();
    idleCycle();
    @(negedge clk);
`ifdef DMA_ECHO_MAP_EN
    checkOutput("lit_echo_addr", bus.mem_addr, 16'hC100);
`else
    checkOutput("lit_echo_addr", bus.mem_addr, 16'hE100);
`endif
    applyStimulus(16'hFF46, 8'h00, 1'b0);
    @(negedge clk);
    checkOutput("lit_echo_rd", {8'd0, bus.cpu_d_in}, 16'h00E1);
    for (int i = 0; i < 160; i++) idleCycle();

    // Reset in the middle of a transfer
    applyStimulus(16'hFF46, 8'hC0, 1'b1);
    for (int i = 0; i < 81; i++) idleCycle();
    applyStimulus(16'hFF46, 8'h00, 1'b0);
    @(negedge clk);
    checkOutput("lit_pre_rst_idx", {8'd0, bus.oam_addr}, 16'd80);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    checkOutput("lit_rst_oam_we", {15'd0, bus.oam_we}, 16'd0);
    checkOutput("lit_rst_busy", {15'd0, bus.dma_busy}, 16'd0);
    checkOutput("lit_rst_ff46", {8'd0, bus.cpu_d_in}, 16'h0000);
    #4;
    rst = 1'b0;
    p0 = pulses;
    for (int i = 0; i < 20; i++) idleCycle();
    @(negedge clk);
    checkOutput("lit_no_oam_after_rst", 16'(pulses - p0), 16'd0);

    // Randomized traffic against the model
    for (int n = 0; n < 4000; n++) begin
      case ($urandom_range(0, 9))
        0:       a = {8'hFF, 8'($urandom)};
        1:       a = 16'hFF46;
        default: a = 16'($urandom_range(0, 16'hFEFF));
      endcase
      if (a == 16'hFF46 && $urandom_range(0, 9) != 0)
        applyStimulus(a, 8'h00, 1'b0);
      else
        applyStimulus(a, 8'($urandom), 1'($urandom));
      if ($urandom_range(0, 399) == 0) begin
        @(posedge clk);
        #3;
        rst = 1'b1;
        #4;
        rst = 1'b0;
      end
    end
    for (int i = 0; i < 170; i++) idleCycle();
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
